// File: rtl/imem_loadable_if.sv
// imem_loadable_if: bundles the fetch and program-load buses of imem_loadable.
//   slave  modport: the instruction memory (drives the *_o signals).
//   master modport: the core fetch stage / boot loader (drives the *_i signals).
// Fetch bus: fetch_req_i, fetch_addr_i -> fetch_ready_o, fetch_valid_o, fetch_instr_o, fetch_fault_o
// Load bus : load_start_i, load_valid_i, load_byte_i, load_last_i -> load_ready_o, load_done_o, load_words_o
interface imem_loadable_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 256
);
  localparam int WW = $clog2(DEPTH) + 1;

  logic            fetch_req_i;
  logic [XLEN-1:0] fetch_addr_i;
  logic            fetch_ready_o;
  logic            fetch_valid_o;
  logic [XLEN-1:0] fetch_instr_o;
  logic            fetch_fault_o;

  logic            load_start_i;
  logic            load_valid_i;
  logic [7:0]      load_byte_i;
  logic            load_last_i;
  logic            load_ready_o;
  logic            load_done_o;
  logic [WW-1:0]   load_words_o;

  modport slave (
    input  fetch_req_i, fetch_addr_i,
    output fetch_ready_o, fetch_valid_o, fetch_instr_o, fetch_fault_o,
    input  load_start_i, load_valid_i, load_byte_i, load_last_i,
    output load_ready_o, load_done_o, load_words_o
  );

  modport master (
    output fetch_req_i, fetch_addr_i,
    input  fetch_ready_o, fetch_valid_o, fetch_instr_o, fetch_fault_o,
    output load_start_i, load_valid_i, load_byte_i, load_last_i,
    input  load_ready_o, load_done_o, load_words_o
  );
endinterface

// File: rtl/imem_loadable.sv
// imem_loadable: run-time loadable instruction memory.
//   - Fetch port: synchronous read, response one cycle after accept; misaligned or
//     out-of-range addresses answer with fault=1 and the NOP word.
//   - Load port : little-endian byte stream assembled into words and written from
//     word 0 upwards; ends on load_last_i or when the array is full.
//   - RUN mode serves fetches, LOAD mode accepts load bytes.
// Ports: clk_i, rst_ni (synchronous, active low), bus (imem_loadable_if.slave).
module imem_loadable #(
  parameter int              XLEN  = 32,
  parameter int              DEPTH = 256,
  parameter logic [XLEN-1:0] NOP   = 32'h00000013
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  imem_loadable_if.slave   bus
);

  localparam int BYTES = XLEN / 8;
  localparam int OFS   = $clog2(BYTES);
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = (OFS > 0) ? OFS : 1;

  typedef enum logic {ST_RUN, ST_LOAD} state_e;

  state_e          state_q, state_d;
  logic [AW:0]     ptr_q, ptr_d;      // next word to write; doubles as words-loaded count
  logic [CW-1:0]   cnt_q, cnt_d;      // byte position within the word being assembled
  logic [XLEN-1:0] asm_q, asm_d;      // bytes received so far; upper bytes kept zero
  logic            done_q, done_d;
  logic            valid_q, fault_q;
  logic [XLEN-1:0] instr_q;

  logic [XLEN-1:0] mem_q [DEPTH];

  logic            fetch_acc;
  logic            fetch_bad;
  logic            byte_acc;
  logic            word_full;
  logic [XLEN-1:0] wdata;
  logic [AW-1:0]   raddr;

  assign fetch_acc = bus.fetch_req_i & (state_q == ST_RUN);
  // Range check is done one bit wider so DEPTH*BYTES never wraps to zero.
  assign fetch_bad = ((bus.fetch_addr_i & XLEN'(BYTES - 1)) != '0) ||
                     ({1'b0, bus.fetch_addr_i} >= (XLEN + 1)'(DEPTH * BYTES));
  assign raddr     = bus.fetch_addr_i[OFS+AW-1:OFS];
  assign byte_acc  = bus.load_valid_i & (state_q == ST_LOAD);
  assign wdata     = asm_q | (XLEN'(bus.load_byte_i) << {cnt_q, 3'b000});

  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    asm_d     = asm_q;
    done_d    = 1'b0;
    word_full = 1'b0;
    if (bus.load_start_i) begin
      // Start (or restart) wins over a byte offered in the same cycle.
      state_d = ST_LOAD;
      ptr_d   = '0;
      cnt_d   = '0;
      asm_d   = '0;
    end else if (byte_acc) begin
      if (cnt_q == CW'(BYTES - 1) || bus.load_last_i) begin
        word_full = 1'b1;
        ptr_d     = ptr_q + 1'b1;
        cnt_d     = '0;
        asm_d     = '0;
        if (bus.load_last_i || ptr_q == (AW + 1)'(DEPTH - 1)) begin
          state_d = ST_RUN;
          done_d  = 1'b1;
        end
      end else begin
        cnt_d = cnt_q + 1'b1;
        asm_d = wdata;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= ST_RUN;
      ptr_q   <= '0;
      cnt_q   <= '0;
      asm_q   <= '0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      asm_q   <= asm_d;
      done_q  <= done_d;
      valid_q <= fetch_acc;
      fault_q <= fetch_acc & fetch_bad;
      if (fetch_acc) begin
        instr_q <= fetch_bad ? NOP : mem_q[raddr];
      end
    end
  end

  // NOTE: the array has no reset; its contents survive reset and change only via the load port.
  always_ff @(posedge clk_i) begin
    if (rst_ni && word_full) begin
      mem_q[ptr_q[AW-1:0]] <= wdata;
    end
  end

  assign bus.fetch_ready_o = (state_q == ST_RUN);
  assign bus.load_ready_o  = (state_q == ST_LOAD);
  assign bus.fetch_valid_o = valid_q;
  assign bus.fetch_fault_o = fault_q;
  assign bus.fetch_instr_o = instr_q;
  assign bus.load_done_o   = done_q;
  assign bus.load_words_o  = ptr_q;

endmodule
